// File: rtl/logiana_trigger.sv
// Two-stage mask/value/edge trigger for the logic analyser sample path.
// Stage A counts occurrences; optional stage B must follow within a window.
module logiana_trigger #(
   parameter int WIDTH = 32
) (
   input  logic             CLK_IN,
   input  logic             RST,
   input  logic             SAMPLE_EN,
   input  logic [WIDTH-1:0] PROBE,
   input  logic             ARM,
   input  logic             CFG_WE,
   input  logic [4:0]       CFG_ADDR,
   input  logic [7:0]       CFG_DATA,
   output logic             TRG,
   output logic             TRG_PULSE,
   output logic [WIDTH-1:0] PROBE_D,
   output logic [1:0]       STATE
);

   localparam int PW = (WIDTH > 32) ? WIDTH : 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_A = 2'd1,
      WAIT_B = 2'd2,
      FIRED  = 2'd3
   } state_t;

   state_t state;

   logic [PW-1:0] mask_a, value_a, edge_a;
   logic [PW-1:0] mask_b, value_b, edge_b;
   logic [7:0]    cnt_a;
   logic [7:0]    window;
   logic          b_en;

   logic [WIDTH-1:0] prev;
   logic             prev_valid;
   logic [7:0]       hit_cnt;
   logic [7:0]       win_cnt;

   logic [4:0] byte_sel;
   assign byte_sel = {CFG_ADDR[1:0], 3'b000};

   // Byte-wide configuration writes, accepted only while idle
   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         mask_a  <= '0;
         value_a <= '0;
         edge_a  <= '0;
         mask_b  <= '0;
         value_b <= '0;
         edge_b  <= '0;
         cnt_a   <= '0;
         window  <= '0;
         b_en    <= 1'b0;
      end else if (CFG_WE && state == IDLE) begin
         case (CFG_ADDR[4:2])
            3'd0: mask_a[byte_sel +: 8]  <= CFG_DATA;
            3'd1: value_a[byte_sel +: 8] <= CFG_DATA;
            3'd2: edge_a[byte_sel +: 8]  <= CFG_DATA;
            3'd3: mask_b[byte_sel +: 8]  <= CFG_DATA;
            3'd4: value_b[byte_sel +: 8] <= CFG_DATA;
            3'd5: edge_b[byte_sel +: 8]  <= CFG_DATA;
            3'd6: begin
               case (CFG_ADDR[1:0])
                  2'd0:    cnt_a  <= CFG_DATA;
                  2'd1:    window <= CFG_DATA;
                  2'd2:    b_en   <= CFG_DATA[0];
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   logic [WIDTH-1:0] eq_a, eq_b, bits_a, bits_b;
   logic [WIDTH-1:0] pv;
   logic             match_a, match_b;

   assign pv   = {WIDTH{prev_valid}};
   assign eq_a = ~(PROBE ^ value_a[WIDTH-1:0]);
   assign eq_b = ~(PROBE ^ value_b[WIDTH-1:0]);

   // Edge bits also need the previous sample at the opposite level
   assign bits_a = ~mask_a[WIDTH-1:0]
                 | (eq_a & (~edge_a[WIDTH-1:0]
                 | (pv & (prev ^ value_a[WIDTH-1:0]))));
   assign bits_b = ~mask_b[WIDTH-1:0]
                 | (eq_b & (~edge_b[WIDTH-1:0]
                 | (pv & (prev ^ value_b[WIDTH-1:0]))));

   assign match_a = &bits_a;
   assign match_b = &bits_b;

   logic [8:0] hit_nxt, hit_need;
   logic [7:0] win_nxt;

   assign hit_nxt  = {1'b0, hit_cnt} + 9'd1;
   assign hit_need = (cnt_a == 8'd0) ? 9'd1 : {1'b0, cnt_a};
   assign win_nxt  = win_cnt + 8'd1;

   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         state      <= IDLE;
         hit_cnt    <= '0;
         win_cnt    <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         PROBE_D    <= '0;
         TRG        <= 1'b0;
         TRG_PULSE  <= 1'b0;
      end else begin
         TRG_PULSE <= 1'b0;
         if (SAMPLE_EN) begin
            PROBE_D    <= PROBE;
            prev       <= PROBE;
            prev_valid <= 1'b1;
         end
         if (ARM) begin
            state      <= WAIT_A;
            hit_cnt    <= '0;
            win_cnt    <= '0;
            prev_valid <= 1'b0;
            TRG        <= 1'b0;
         end else begin
            unique case (state)
               IDLE: ;
               WAIT_A: begin
                  if (SAMPLE_EN && match_a) begin
                     if (hit_nxt >= hit_need) begin
                        hit_cnt <= '0;
                        win_cnt <= '0;
                        if (b_en) begin
                           state <= WAIT_B;
                        end else begin
                           state     <= FIRED;
                           TRG       <= 1'b1;
                           TRG_PULSE <= 1'b1;
                        end
                     end else begin
                        hit_cnt <= hit_nxt[7:0];
                     end
                  end
               end
               WAIT_B: begin
                  if (SAMPLE_EN) begin
                     if (match_b) begin
                        state     <= FIRED;
                        TRG       <= 1'b1;
                        TRG_PULSE <= 1'b1;
                     end else if (window != 8'd0 && win_nxt == window) begin
                        state   <= WAIT_A;
                        hit_cnt <= '0;
                        win_cnt <= '0;
                     end else begin
                        win_cnt <= win_nxt;
                     end
                  end
               end
               FIRED: ;
            endcase
         end
      end
   end

   assign STATE = state;

endmodule

// File: tb/tb_logiana_trigger.sv
// Directed bench for logiana_trigger: level, edge, count, window,
// config gating, reset and re-arm scenarios.
module tb_logiana_trigger;

   logic        CLK_IN = 1'b0;
   logic        RST = 1'b0;
   logic        SAMPLE_EN = 1'b0;
   logic [31:0] PROBE = '0;
   logic        ARM = 1'b0;
   logic        CFG_WE = 1'b0;
   logic [4:0]  CFG_ADDR = '0;
   logic [7:0]  CFG_DATA = '0;
   logic        TRG;
   logic        TRG_PULSE;
   logic [31:0] PROBE_D;
   logic [1:0]  STATE;

   int tests = 0;
   int fails = 0;

   logiana_trigger #(.WIDTH(32)) dut (
      .CLK_IN(CLK_IN),
      .RST(RST),
      .SAMPLE_EN(SAMPLE_EN),
      .PROBE(PROBE),
      .ARM(ARM),
      .CFG_WE(CFG_WE),
      .CFG_ADDR(CFG_ADDR),
      .CFG_DATA(CFG_DATA),
      .TRG(TRG),
      .TRG_PULSE(TRG_PULSE),
      .PROBE_D(PROBE_D),
      .STATE(STATE)
   );

   always #5 CLK_IN = ~CLK_IN;

   task automatic cyc(input logic se, input logic [31:0] p,
                      input logic arm);
      SAMPLE_EN = se;
      PROBE = p;
      ARM = arm;
      @(posedge CLK_IN);
      #1;
      SAMPLE_EN = 1'b0;
      ARM = 1'b0;
   endtask

   task automatic rst_cyc();
      RST = 1'b1;
      @(posedge CLK_IN);
      #1;
      RST = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      CFG_WE = 1'b1;
      CFG_ADDR = a;
      CFG_DATA = d;
      @(posedge CLK_IN);
      #1;
      CFG_WE = 1'b0;
   endtask

   task automatic wr32(input logic [4:0] base, input logic [31:0] v);
      for (int i = 0; i < 4; i++)
         wr(base + 5'(i), v[8*i +: 8]);
   endtask

   task automatic test_reset();
      rst_cyc();
      tests++;
      if ({TRG, TRG_PULSE, STATE} !== 4'b0000 || PROBE_D !== 32'h0) begin
         $display("FAIL reset: trg=%b pls=%b st=%0d pd=%h want 0",
                  TRG, TRG_PULSE, STATE, PROBE_D);
         fails++;
      end
   endtask

   task automatic test_level();
      rst_cyc();
      wr32(5'd0, 32'h0000FFFF);
      wr32(5'd4, 32'h00001234);
      cyc(1'b0, 32'h0, 1'b1);
      tests++;
      if (STATE !== 2'd1) begin
         $display("FAIL level_arm: st=%0d want 1", STATE);
         fails++;
      end
      cyc(1'b1, 32'h00001233, 1'b0);
      tests++;
      if (TRG !== 1'b0) begin
         $display("FAIL level_miss: trg=%b want 0", TRG);
         fails++;
      end
      cyc(1'b1, 32'hFFFF1234, 1'b0);
      tests++;
      if (TRG !== 1'b1 || TRG_PULSE !== 1'b1 || PROBE_D !== 32'hFFFF1234) begin
         $display("FAIL level_hit: trg=%b pls=%b pd=%h want 1 1 ffff1234",
                  TRG, TRG_PULSE, PROBE_D);
         fails++;
      end
      cyc(1'b0, 32'h0, 1'b0);
      tests++;
      if (TRG !== 1'b1 || TRG_PULSE !== 1'b0 || STATE !== 2'd3) begin
         $display("FAIL level_hold: trg=%b pls=%b st=%0d want 1 0 3",
                  TRG, TRG_PULSE, STATE);
         fails++;
      end
      cyc(1'b1, 32'hFFFF1234, 1'b0);
      tests++;
      if (TRG !== 1'b1 || TRG_PULSE !== 1'b0) begin
         $display("FAIL level_nopulse: trg=%b pls=%b want 1 0",
                  TRG, TRG_PULSE);
         fails++;
      end
   endtask

   task automatic test_arm_fired();
      cyc(1'b1, 32'h00001234, 1'b1);
      tests++;
      if (TRG !== 1'b0 || TRG_PULSE !== 1'b0 || STATE !== 2'd1
          || PROBE_D !== 32'h00001234) begin
         $display("FAIL rearm: trg=%b pls=%b st=%0d pd=%h want 0 0 1 1234",
                  TRG, TRG_PULSE, STATE, PROBE_D);
         fails++;
      end
      cyc(1'b1, 32'h00005234, 1'b0);
      tests++;
      if (TRG !== 1'b0 || STATE !== 2'd1) begin
         $display("FAIL rearm_miss: trg=%b st=%0d want 0 1", TRG, STATE);
         fails++;
      end
      cyc(1'b1, 32'h00001234, 1'b0);
      tests++;
      if (TRG !== 1'b1 || TRG_PULSE !== 1'b1) begin
         $display("FAIL rearm_hit: trg=%b pls=%b want 1 1", TRG, TRG_PULSE);
         fails++;
      end
   endtask

   task automatic test_edge();
      rst_cyc();
      wr32(5'd0, 32'h1);
      wr32(5'd4, 32'h1);
      wr32(5'd8, 32'h1);
      cyc(1'b0, 32'h0, 1'b1);
      cyc(1'b1, 32'h1, 1'b0);
      tests++;
      if (TRG !== 1'b0) begin
         $display("FAIL edge_first: trg=%b want 0", TRG);
         fails++;
      end
      cyc(1'b1, 32'h0, 1'b0);
      cyc(1'b1, 32'h1, 1'b0);
      tests++;
      if (TRG !== 1'b1 || TRG_PULSE !== 1'b1) begin
         $display("FAIL edge_rise: trg=%b pls=%b want 1 1", TRG, TRG_PULSE);
         fails++;
      end
      rst_cyc();
      wr32(5'd0, 32'h1);
      wr32(5'd8, 32'h1);
      cyc(1'b0, 32'h0, 1'b1);
      cyc(1'b1, 32'h1, 1'b0);
      tests++;
      if (TRG !== 1'b0) begin
         $display("FAIL edge_fall_first: trg=%b want 0", TRG);
         fails++;
      end
      cyc(1'b1, 32'h0, 1'b0);
      tests++;
      if (TRG !== 1'b1) begin
         $display("FAIL edge_fall: trg=%b want 1", TRG);
         fails++;
      end
   endtask

   task automatic test_count();
      rst_cyc();
      wr32(5'd0, 32'h1);
      wr32(5'd4, 32'h1);
      wr(5'd24, 8'd3);
      cyc(1'b0, 32'h0, 1'b1);
      cyc(1'b1, 32'h1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0);
      cyc(1'b1, 32'h0, 1'b0);
      cyc(1'b0, 32'h1, 1'b0);
      cyc(1'b1, 32'h1, 1'b0);
      cyc(1'b0, 32'h1, 1'b0);
      cyc(1'b0, 32'h1, 1'b0);
      tests++;
      if (STATE !== 2'd1 || TRG !== 1'b0) begin
         $display("FAIL count_gap: st=%0d trg=%b want 1 0", STATE, TRG);
         fails++;
      end
      cyc(1'b1, 32'h1, 1'b0);
      tests++;
      if (TRG !== 1'b1 || STATE !== 2'd3) begin
         $display("FAIL count_hit: trg=%b st=%0d want 1 3", TRG, STATE);
         fails++;
      end
   endtask

   task automatic test_window();
      rst_cyc();
      wr32(5'd0, 32'hFF);
      wr32(5'd4, 32'h0A);
      wr32(5'd12, 32'hFF);
      wr32(5'd16, 32'h0B);
      wr(5'd25, 8'd2);
      wr(5'd26, 8'd1);
      cyc(1'b0, 32'h0, 1'b1);
      cyc(1'b1, 32'h0A, 1'b0);
      tests++;
      if (STATE !== 2'd2) begin
         $display("FAIL win_a: st=%0d want 2", STATE);
         fails++;
      end
      cyc(1'b1, 32'h00, 1'b0);
      cyc(1'b1, 32'h00, 1'b0);
      tests++;
      if (STATE !== 2'd1) begin
         $display("FAIL win_expire: st=%0d want 1", STATE);
         fails++;
      end
      cyc(1'b1, 32'h0B, 1'b0);
      tests++;
      if (TRG !== 1'b0 || STATE !== 2'd1) begin
         $display("FAIL win_late_b: trg=%b st=%0d want 0 1", TRG, STATE);
         fails++;
      end
      cyc(1'b1, 32'h0A, 1'b0);
      cyc(1'b1, 32'h00, 1'b0);
      cyc(1'b1, 32'h0B, 1'b0);
      tests++;
      if (TRG !== 1'b1 || STATE !== 2'd3 || PROBE_D !== 32'h0B) begin
         $display("FAIL win_hit: trg=%b st=%0d pd=%h want 1 3 0b",
                  TRG, STATE, PROBE_D);
         fails++;
      end
   endtask

   task automatic test_cfg_gate();
      rst_cyc();
      wr32(5'd0, 32'hFF);
      wr32(5'd4, 32'h55);
      cyc(1'b0, 32'h0, 1'b1);
      wr(5'd0, 8'h00);
      cyc(1'b1, 32'h00, 1'b0);
      tests++;
      if (TRG !== 1'b0 || STATE !== 2'd1) begin
         $display("FAIL cfg_gate: trg=%b st=%0d want 0 1", TRG, STATE);
         fails++;
      end
      cyc(1'b1, 32'h55, 1'b0);
      tests++;
      if (TRG !== 1'b1) begin
         $display("FAIL cfg_gate_hit: trg=%b want 1", TRG);
         fails++;
      end
   endtask

   task automatic test_reset_mid();
      rst_cyc();
      wr32(5'd0, 32'hFF);
      wr32(5'd4, 32'h0A);
      wr(5'd26, 8'd1);
      cyc(1'b0, 32'h0, 1'b1);
      cyc(1'b1, 32'h0A, 1'b0);
      tests++;
      if (STATE !== 2'd2) begin
         $display("FAIL rst_pre: st=%0d want 2", STATE);
         fails++;
      end
      rst_cyc();
      tests++;
      if ({TRG, TRG_PULSE, STATE} !== 4'b0000 || PROBE_D !== 32'h0) begin
         $display("FAIL rst_mid: trg=%b pls=%b st=%0d pd=%h want 0",
                  TRG, TRG_PULSE, STATE, PROBE_D);
         fails++;
      end
      cyc(1'b0, 32'h0, 1'b1);
      cyc(1'b1, 32'h12345678, 1'b0);
      tests++;
      if (TRG !== 1'b1 || STATE !== 2'd3) begin
         $display("FAIL rst_cfg_zero: trg=%b st=%0d want 1 3", TRG, STATE);
         fails++;
      end
      RST = 1'b1;
      ARM = 1'b1;
      SAMPLE_EN = 1'b1;
      PROBE = 32'hDEADBEEF;
      @(posedge CLK_IN);
      #1;
      RST = 1'b0;
      ARM = 1'b0;
      SAMPLE_EN = 1'b0;
      tests++;
      if ({TRG, TRG_PULSE, STATE} !== 4'b0000 || PROBE_D !== 32'h0) begin
         $display("FAIL rst_arm: trg=%b pls=%b st=%0d pd=%h want 0",
                  TRG, TRG_PULSE, STATE, PROBE_D);
         fails++;
      end
   endtask

   initial begin
      test_reset();
      test_level();
      test_arm_fired();
      test_edge();
      test_count();
      test_window();
      test_cfg_gate();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
